// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and runs MULT/MULTU/DIV/DIVU/MADD/MSUB
// with fixed latencies; MTHI/MTLO write HI/LO directly while idle.
`timescale 1ns/1ps
module e_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  op_e  op_in;
  logic commit;

  // Datapath operates only on latched operands, so the result is stable for the whole run.
  logic [2*WIDTH-1:0] a_s, b_s, a_z, b_z, prod_s, prod_u, hilo, result;
  logic               neg_a, neg_b, is_div, div_by_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, dsor, q_mag, r_mag, quo, rem;

  always_comb begin
    a_s    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    b_s    = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    a_z    = {{WIDTH{1'b0}}, a_q};
    b_z    = {{WIDTH{1'b0}}, b_q};
    prod_s = a_s * b_s;
    prod_u = a_z * b_z;
    hilo   = {hi_q, lo_q};

    // Signed division via magnitudes: the most-negative/-1 case then wraps to itself.
    neg_a  = (op_q == OP_DIV) && a_q[WIDTH-1];
    neg_b  = (op_q == OP_DIV) && b_q[WIDTH-1];
    mag_a  = neg_a ? -a_q : a_q;
    mag_b  = neg_b ? -b_q : b_q;
    dsor   = (mag_b == '0) ? WIDTH'(1) : mag_b;
    q_mag  = mag_a / dsor;
    r_mag  = mag_a % dsor;
    quo    = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem    = neg_a ? -r_mag : r_mag;

    is_div      = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_by_zero = is_div && (b_q == '0);

    result = hilo;
    case (op_q)
      OP_MULT:          result = prod_s;
      OP_MULTU:         result = prod_u;
      OP_MADD:          result = hilo + prod_s;
      OP_MSUB:          result = hilo - prod_s;
      OP_DIV, OP_DIVU:  result = {rem, quo};
      default:          result = hilo;
    endcase
  end

  assign op_in  = op_e'(op);
  assign commit = (state_q == RUN) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == RUN) begin
      if (commit) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!div_by_zero) begin
          hi_d = result[2*WIDTH-1:WIDTH];
          lo_d = result[WIDTH-1:0];
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // A mult/div start on the commit edge is accepted so busy stays high back-to-back.
    if (start) begin
      case (op_in)
        OP_MTHI: if (state_q == IDLE) hi_d = a;
        OP_MTLO: if (state_q == IDLE) lo_d = a;
        default: begin
          if (state_q == IDLE || commit) begin
            state_d = RUN;
            busy_d  = 1'b1;
            op_d    = op_in;
            a_d     = a;
            b_d     = b;
            cnt_d   = (op_in == OP_DIV || op_in == OP_DIVU) ? CW'(DIV_LAT - 1)
                                                             : CW'(MUL_LAT - 1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO and commit edge, a monitor
// pops and compares on every done pulse and checks busy each cycle.
`timescale 1ns/1ps
module tb_e_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned ML = 5;
  localparam int unsigned DL = 10;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  e_mdu #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int unsigned edge_n   = 0;
  int unsigned busy_end = 0;
  bit          mon_en   = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (edge %0d)", name, got, exp, edge_n);
  endtask

  // Reference arithmetic on native 32/64-bit types.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] av,
                                         input logic [31:0] bv, input logic [63:0] hl);
    longint sp;
    int     q, r;
    sp = longint'($signed(av)) * longint'($signed(bv));
    case (o)
      3'd0: return sp;
      3'd1: return {32'b0, av} * {32'b0, bv};
      3'd6: return hl + sp;
      3'd7: return hl - sp;
      3'd2: begin
        if (bv == 0) return hl;
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(av) / $signed(bv);
        r = $signed(av) % $signed(bv);
        return {r, q};
      end
      3'd3: begin
        if (bv == 0) return hl;
        return {av % bv, av / bv};
      end
      default: return hl;
    endcase
  endfunction

  // Called just after a negedge; the start is seen on the next rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    int unsigned k, lat;
    k = edge_n + 1;
    start = 1'b1; op = o; a = av; b = bv;
    if (o == 3'd4 || o == 3'd5) begin
      if (k > busy_end) begin
        if (o == 3'd4) m_hi = av; else m_lo = av;
      end
    end else if (k >= busy_end) begin
      lat = (o == 3'd2 || o == 3'd3) ? DL : ML;
      {m_hi, m_lo} = ref_md(o, av, bv, {m_hi, m_lo});
      sb.push_back('{m_hi, m_lo, k + lat});
      busy_end = k + lat;
    end
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_commit_edge();
    while (edge_n + 1 < busy_end) @(negedge clk);
  endtask

  always @(posedge clk) begin
    edge_n++;
    #1;
    if (mon_en) begin
      check("busy", busy, edge_n < busy_end);
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done=1 at edge %0d, required 0", edge_n);
        end else begin
          e_m = sb.pop_front();
          check("done_edge", edge_n, e_m.at);
          check("done_hi", hi, e_m.hi);
          check("done_lo", lo, e_m.lo);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int unsigned sel, gap;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(3'd0, -32'sd3, 32'd7);
    drain();
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    drain();
    check("t2_hi", hi, 32'd1);
    check("t2_lo", lo, 32'hFFFF_FFFE);
    issue(3'd6, 32'd1, 32'd1);
    drain();
    check("t2_madd_hi", hi, 32'd1);
    check("t2_madd_lo", lo, 32'hFFFF_FFFF);

    issue(3'd2, -32'sd7, 32'd2);
    drain();
    check("t3_lo", lo, 32'hFFFF_FFFD);
    check("t3_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd0);
    drain();
    check("t3_dz_lo", lo, 32'hFFFF_FFFD);
    check("t3_dz_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    issue(3'd0, 32'd5, 32'd5);
    drain();
    check("t4_lo", lo, 32'h8000_0000);
    check("t4_hi", hi, 32'd0);

    issue(3'd5, 32'h1234, 32'd0);
    check("t5_mtlo", lo, 32'h1234);
    issue(3'd0, 32'd3, 32'd4);
    issue(3'd4, 32'hDEAD, 32'd0);
    drain();
    check("t5_hi", hi, 32'd0);
    check("t5_lo", lo, 32'd12);

    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    busy_end = 0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    check("t6_hi", hi, 0);
    check("t6_lo", lo, 0);
    check("t6_busy", busy, 0);
    repeat (12) @(negedge clk);
    issue(3'd0, 32'd6, 32'd7);
    wait_commit_edge();
    issue(3'd1, 32'hFFFF_0000, 32'h0001_0000);
    drain();
    check("t6_b2b_hi", hi, 32'h0000_FFFF);
    check("t6_b2b_lo", lo, 32'd0);

    for (int i = 0; i < 80; i++) begin
      ro  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      ra  = (sel == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel == 2) ? 32'($urandom_range(1, 300)) : $urandom;
      gap = $urandom_range(0, 3);
      if (gap == 1) wait_commit_edge();
      else if (gap >= 2) begin
        while (edge_n + 1 <= busy_end) @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      issue(ro, ra, rb);
    end
    drain();
    repeat (2) @(negedge clk);
    check("final_hi", hi, m_hi);
    check("final_lo", lo, m_lo);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
